// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and default sizes for the mux scan controller
package mux_scan_pkg;

  localparam int MUX_NR_CH = 4;
  localparam int MUX_SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/scan_hold_timer.sv
// rtl/scan_hold_timer.sv - settle-window counter; expired marks the last settle cycle of a channel
module scan_hold_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = en && (cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      // wrap back to zero so the next channel starts a fresh window
      cnt <= expired ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - drives the 4:1 bit-select mux, scans every channel and rebuilds the word
// Optional parity output built only when MUX_SCAN_PARITY_EN is defined.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NR_CH       = MUX_NR_CH,
  parameter int SEL_W       = MUX_SEL_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NR_CH-1:0] data_in,
  output logic [SEL_W-1:0] sel_out,
  output logic [NR_CH-1:0] a_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [NR_CH-1:0] result,
  output logic             mismatch,
  output logic             parity
);

  scan_state_e state_q, state_d;
  logic [NR_CH-1:0] result_d;
  logic             expired;
  logic             last_ch;
  logic             accept;

  assign last_ch = (sel_out == SEL_W'(NR_CH - 1));
  assign accept  = (state_q == IDLE) && start;

  scan_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .en     (state_q == SETTLE),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          result_d = '0;
        end
      end
      SETTLE: begin
        if (expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        result_d[sel_out] = y_in;
        state_d = last_ch ? DONE : SETTLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_out  <= '0;
      a_out    <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      result <= result_d;
      busy   <= (state_d != IDLE);
      done   <= (state_d == DONE);
      if (accept) begin
        a_out   <= data_in;
        sel_out <= '0;
      end
      if (state_q == SAMPLE && !last_ch) sel_out <= sel_out + 1'b1;
      // evaluate against the final word so the flag is valid with the done pulse
      if (state_q == SAMPLE && last_ch) mismatch <= (result_d != a_out);
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)                          parity <= 1'b0;
    else if (state_q == SAMPLE && last_ch) parity <= ^result_d;
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a behavioural keyed mux
module tb_mux_scan_ctrl;

  localparam int H  = 2;
  localparam int LAT = 4 * (H + 1) + 1;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic [3:0] data_in = 0;
  logic [1:0] sel_out;
  logic [3:0] a_out;
  logic       y_in;
  logic       busy, done, mismatch, parity;
  logic [3:0] result;
  int         fault_ch = -1;

  logic       start1 = 0;
  logic [3:0] data1 = 0;
  logic [1:0] sel1;
  logic [3:0] a1, result1;
  logic       y1, busy1, done1, mm1, par1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // keyed mux model with optional stuck-at-0 on one channel
  assign y_in = (fault_ch == int'(sel_out)) ? 1'b0 : a_out[sel_out];
  assign y1   = a1[sel1];

  mux_scan_ctrl #(.NR_CH(4), .SEL_W(2), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .sel_out(sel_out),
    .a_out(a_out), .y_in(y_in), .busy(busy), .done(done), .result(result),
    .mismatch(mismatch), .parity(parity)
  );

  mux_scan_ctrl #(.NR_CH(4), .SEL_W(2), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1), .sel_out(sel1),
    .a_out(a1), .y_in(y1), .busy(busy1), .done(done1), .result(result1),
    .mismatch(mm1), .parity(par1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_parity(input logic [3:0] w);
`ifdef MUX_SCAN_PARITY_EN
    return ^w;
`else
    return 1'b0 & w[0];
`endif
  endfunction

  // Runs one scan from an IDLE cycle; returns observations and ends in the following IDLE cycle.
  task automatic run_scan(input logic [3:0] d, input int fch, output int dcyc,
                          output logic [3:0] res, output logic mm, output logic par,
                          output int sel_bad);
    fault_ch = fch;
    data_in = d;
    start = 1;
    tick();
    start = 0;
    dcyc = -1;
    sel_bad = 0;
    res = 'x; mm = 'x; par = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (k < LAT && sel_out !== 2'((k - 1) / (H + 1))) sel_bad++;
      if (k < LAT && a_out !== d) sel_bad++;
      data_in = 4'($urandom);
      if (done === 1'b1) begin
        dcyc = k; res = result; mm = mismatch; par = parity;
        break;
      end
      tick();
    end
    tick();
    fault_ch = -1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    checks++; if (sel_out !== 0)  begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_out); end
    checks++; if (a_out !== 0)    begin failures++; $display("FAIL reset_a got=%b exp=0", a_out); end
    checks++; if (result !== 0)   begin failures++; $display("FAIL reset_result got=%b exp=0", result); end
    checks++; if ({busy, done, mismatch, parity} !== 4'b0)
      begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, mismatch, parity}); end
  endtask

  task automatic test_basic();
    int dc, sb; logic [3:0] r; logic m, p;
    run_scan(4'b1010, -1, dc, r, m, p, sb);
    checks++; if (dc != LAT)     begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", dc, LAT); end
    checks++; if (r !== 4'b1010) begin failures++; $display("FAIL basic_result got=%b exp=1010", r); end
    checks++; if (m !== 1'b0)    begin failures++; $display("FAIL basic_mismatch got=%b exp=0", m); end
    checks++; if (sb != 0)       begin failures++; $display("FAIL basic_sel_hold got=%0d bad exp=0", sb); end
    checks++; if (result !== 4'b1010 || sel_out !== 2'd3)
      begin failures++; $display("FAIL basic_hold_after_done got=%b/%0d exp=1010/3", result, sel_out); end
  endtask

  task automatic test_fault();
    int dc, sb; logic [3:0] r; logic m, p;
    run_scan(4'b1000, 3, dc, r, m, p, sb);
    checks++; if (r !== 4'b0000) begin failures++; $display("FAIL fault_result got=%b exp=0000", r); end
    checks++; if (m !== 1'b1)    begin failures++; $display("FAIL fault_mismatch got=%b exp=1", m); end
    checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL fault_mm_hold got=%b exp=1", mismatch); end
  endtask

  task automatic test_busy();
    int ndone = 0;
    data_in = 4'b0101; start = 1; tick();
    for (int k = 1; k <= 20; k++) begin
      start = (k == 5 || k == LAT) ? 1'b1 : 1'b0;
      if (done === 1'b1) ndone++;
      if (k == LAT) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_in_done got=%b exp=1", busy); end
      end
      if (k == LAT + 1) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_drop got=%b exp=0", busy); end
      end
      tick();
    end
    start = 0;
    checks++; if (ndone != 1) begin failures++; $display("FAIL busy_one_done got=%0d exp=1", ndone); end
    checks++; if (result !== 4'b0101) begin failures++; $display("FAIL busy_result got=%b exp=0101", result); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0, dc, sb; logic [3:0] r; logic m, p;
    data_in = 4'b1111; start = 1; tick(); start = 0;
    for (int k = 1; k < 7; k++) tick();
    rst = 1; tick(); rst = 0;
    checks++; if ({sel_out, a_out, result, busy, done, mismatch, parity} !== '0)
      begin failures++; $display("FAIL midrst_values got=%b exp=0", {sel_out, a_out, result, busy, done, mismatch, parity}); end
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
    run_scan(4'b0110, -1, dc, r, m, p, sb);
    checks++; if (r !== 4'b0110 || dc != LAT)
      begin failures++; $display("FAIL midrst_rescan got=%b@%0d exp=0110@%0d", r, dc, LAT); end
  endtask

  task automatic test_back_to_back();
    int dcs[$]; logic [3:0] rs[$];
    data_in = 4'b1111; start = 1; tick();
    data_in = 4'b0001;
    for (int k = 1; k <= 2 * LAT + 1; k++) begin
      if (k == 2 * LAT + 1) start = 0;
      if (done === 1'b1) begin dcs.push_back(k); rs.push_back(result); end
      tick();
    end
    start = 0;
    tick();
    checks++; if (dcs.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", dcs.size()); end
    else begin
      checks++; if (dcs[0] != LAT || dcs[1] != 2 * LAT + 1)
        begin failures++; $display("FAIL b2b_cycles got=%0d,%0d exp=%0d,%0d", dcs[0], dcs[1], LAT, 2 * LAT + 1); end
      checks++; if (rs[0] !== 4'b1111 || rs[1] !== 4'b0001)
        begin failures++; $display("FAIL b2b_results got=%b,%b exp=1111,0001", rs[0], rs[1]); end
    end
  endtask

  task automatic test_parity();
    int dc, sb; logic [3:0] r; logic m, p;
    run_scan(4'b0111, -1, dc, r, m, p, sb);
    checks++; if (p !== exp_parity(4'b0111))
      begin failures++; $display("FAIL parity_0111 got=%b exp=%b", p, exp_parity(4'b0111)); end
    checks++; if (parity !== p) begin failures++; $display("FAIL parity_hold got=%b exp=%b", parity, p); end
  endtask

  task automatic test_random();
    int dc, sb, fch; logic [3:0] d, r, er; logic m, p;
    for (int n = 0; n < 8; n++) begin
      d = 4'($urandom);
      fch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      er = d;
      if (fch >= 0) er[fch] = 1'b0;
      run_scan(d, fch, dc, r, m, p, sb);
      checks++;
      if (r !== er || m !== (er != d) || p !== exp_parity(er) || dc != LAT || sb != 0) begin
        failures++;
        $display("FAIL random_%0d d=%b f=%0d got r=%b m=%b p=%b lat=%0d sb=%0d exp r=%b m=%b p=%b lat=%0d",
                 n, d, fch, r, m, p, dc, sb, er, (er != d), exp_parity(er), LAT);
      end
    end
  endtask

  task automatic test_hold1();
    int dc = -1; logic [3:0] r = 'x;
    data1 = 4'b1101; start1 = 1; tick(); start1 = 0;
    for (int k = 1; k <= 30; k++) begin
      data1 = 4'($urandom);
      if (done1 === 1'b1) begin dc = k; r = result1; break; end
      tick();
    end
    tick();
    checks++; if (dc != 9) begin failures++; $display("FAIL hold1_latency got=%0d exp=9", dc); end
    checks++; if (r !== 4'b1101) begin failures++; $display("FAIL hold1_result got=%b exp=1101", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    test_random();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
